// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/halt/step controller: FSM states, host command
// encodings and the breakpoint-match rule.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RESET_HOLD = 2'd0,
      ST_HALTED     = 2'd1,
      ST_RUNNING    = 2'd2,
      ST_STEPPING   = 2'd3
   } state_t;

   localparam logic [2:0] CMD_NOP     = 3'd0;
   localparam logic [2:0] CMD_RUN     = 3'd1;
   localparam logic [2:0] CMD_HALT    = 3'd2;
   localparam logic [2:0] CMD_STEP    = 3'd3;
   localparam logic [2:0] CMD_SETADDR = 3'd4;
   localparam logic [2:0] CMD_LOAD    = 3'd5;
   localparam logic [2:0] CMD_SETBP   = 3'd6;
   localparam logic [2:0] CMD_CLRBP   = 3'd7;

   // The first advance after RUN/STEP ignores the breakpoint so a resume
   // from the breakpoint PC executes that instruction.
   function automatic logic bp_match(input logic bp_en, input logic pc_eq,
                                     input logic bp_skip);
      return bp_en && pc_eq && !bp_skip;
   endfunction

endpackage

// File: rtl/step_counter.sv
// Remaining-instruction counter for single/multi step; a zero load is
// treated as a single step.
module step_counter
   import run_ctrl_pkg::*;
#(
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [STEP_W-1:0] load_val,
   input  logic              dec,
   output logic              last
);

   logic [STEP_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= (load_val == '0) ? STEP_W'(1) : load_val;
      end else if (dec) begin
         count <= count - STEP_W'(1);
      end
   end

   assign last = (count == STEP_W'(1));

endmodule

// File: rtl/run_controller.sv
// Run/halt/step sequencer for the single-cycle core: holds the core in reset,
// gates its advance enable, loads instruction memory and stops on breakpoints.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter  int XLEN              = 32,
   parameter  int IMEM_DEPTH        = 256,
   parameter  int RESET_HOLD_CYCLES = 4,
   parameter  int STEP_W            = 16,
   localparam int ADDR_W            = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [XLEN-1:0]   cmd_arg,
   input  logic [XLEN-1:0]   pc,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              halted,
   output logic              bp_hit,
   output logic              cmd_err,
   output logic [31:0]       cycle_count
);

   localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD_CYCLES - 1);

   state_t            state, state_nxt;
   logic [15:0]       hold_cnt;
   logic [ADDR_W-1:0] load_ptr;
   logic [XLEN-1:0]   bp_addr;
   logic              bp_en, bp_skip;
   logic              accept, in_halted, in_exec, match, go;
   logic              step_load, step_dec, step_last;

   assign accept    = cmd_valid && cmd_ready;
   assign in_halted = (state == ST_HALTED);
   assign in_exec   = (state == ST_RUNNING) || (state == ST_STEPPING);
   assign match     = bp_match(bp_en, pc == bp_addr, bp_skip);
   assign go        = accept && in_halted && (cmd_op == CMD_RUN || cmd_op == CMD_STEP);
   assign step_load = accept && in_halted && (cmd_op == CMD_STEP);
   assign step_dec  = cpu_en && (state == ST_STEPPING);

   step_counter #(.STEP_W(STEP_W)) u_step_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (step_load),
      .load_val (cmd_arg[STEP_W-1:0]),
      .dec      (step_dec),
      .last     (step_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RESET_HOLD;
      else     state <= state_nxt;
   end

   // A breakpoint match, a HALT and step completion all land in HALTED.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_HALTED;
         ST_HALTED: begin
            if (accept && cmd_op == CMD_RUN)       state_nxt = ST_RUNNING;
            else if (accept && cmd_op == CMD_STEP) state_nxt = ST_STEPPING;
         end
         default: begin
            if (match || (accept && cmd_op == CMD_HALT))  state_nxt = ST_HALTED;
            else if (state == ST_STEPPING && step_last)   state_nxt = ST_HALTED;
         end
      endcase
   end

   always_comb begin
      cpu_rst   = (state == ST_RESET_HOLD);
      cmd_ready = (state != ST_RESET_HOLD);
      halted    = in_halted;
      cpu_en    = in_exec && !match;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt    <= '0;
         cycle_count <= '0;
         bp_skip     <= 1'b0;
         bp_hit      <= 1'b0;
         cmd_err     <= 1'b0;
      end else begin
         if (state == ST_RESET_HOLD) hold_cnt <= hold_cnt + 16'd1;
         if (cpu_en) cycle_count <= cycle_count + 32'd1;
         if (go)          bp_skip <= 1'b1;
         else if (cpu_en) bp_skip <= 1'b0;
         if (go)                  bp_hit <= 1'b0;
         else if (in_exec && match) bp_hit <= 1'b1;
         cmd_err <= accept && in_exec &&
                    (cmd_op == CMD_RUN || cmd_op == CMD_STEP ||
                     cmd_op == CMD_SETADDR || cmd_op == CMD_LOAD);
      end
   end

   // Loader and breakpoint registers; loads are only honoured while halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_ptr   <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         bp_en      <= 1'b0;
         bp_addr    <= '0;
      end else begin
         imem_we <= accept && in_halted && (cmd_op == CMD_LOAD);
         if (accept && in_halted) begin
            case (cmd_op)
               CMD_SETADDR: load_ptr <= cmd_arg[ADDR_W-1:0];
               CMD_LOAD: begin
                  imem_waddr <= load_ptr;
                  imem_wdata <= cmd_arg;
                  load_ptr   <= load_ptr + ADDR_W'(1);
               end
               default: ;
            endcase
         end
         if (accept && cmd_op == CMD_SETBP) begin
            bp_en   <= 1'b1;
            bp_addr <= cmd_arg;
         end else if (accept && cmd_op == CMD_CLRBP) begin
            bp_en <= 1'b0;
         end
      end
   end

endmodule
